// File: rtl/i8085_bus_pkg.sv
// Shared bus definitions for the 8085-style memory responder: FSM states and S1/S0 cycle codes.
package i8085_bus_pkg;

    localparam int unsigned WAIT_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_RD_DRIVE = 2'd2,
        ST_WR_HOLD  = 2'd3
    } bus_state_e;

    localparam logic [1:0] CYC_FETCH = 2'b11;
    localparam logic [1:0] CYC_READ  = 2'b10;
    localparam logic [1:0] CYC_WRITE = 2'b01;
    localparam logic [1:0] CYC_HALT  = 2'b00;

endpackage

// File: rtl/responder_ram.sv
// Byte-wide responder storage: one synchronous write port, one asynchronous read port, no reset.
module responder_ram #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata_c
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory/IO responder on a multiplexed 8085-style bus: address latch, wait-state insertion,
// read drive and write capture into a local RAM, with a sticky protocol-error flag.
module mem_bus_responder
    import i8085_bus_pkg::*;
#(
    parameter logic [15:0] BASE        = 16'h0000,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 1,
    parameter bit          IO_SPACE    = 1'b0
) (
    input  logic       phi1,
    input  logic       reset,
    input  logic       ALE,
    input  logic       IOMn,
    input  logic       S1,
    input  logic       S0,
    input  logic       RDn,
    input  logic       WRn,
    input  logic [7:0] a_hi,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       READY,
    output logic       bus_err
);

    localparam logic [15:0]           HI_MASK   = 16'hFFFF << ADDR_W;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES == 0) ? WAIT_CNT_W'(0) : WAIT_CNT_W'(WAIT_STATES - 1);

    logic [15:0]           addr_q;
    logic                  iom_q;
    logic [1:0]            cyc_q;
    logic                  rd_hist_q;
    logic                  wr_hist_q;
    logic [7:0]            wdata_q;

    bus_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  is_rd_q, is_rd_d;
    logic                  ready_q, ready_d;
    logic                  oe_q, oe_d;
    logic [7:0]            ad_out_q, ad_out_d;
    logic                  err_q, err_d;

    logic                  sel_c;
    logic                  rd_start_c;
    logic                  wr_start_c;
    logic                  both_low_c;
    logic                  ram_we_c;
    logic [7:0]            rd_data_c;

    // Address/status latch, strobe history and write-data capture
    always_ff @(posedge phi1 or negedge reset) begin
        if (!reset) begin
            addr_q    <= 16'h0000;
            iom_q     <= 1'b0;
            cyc_q     <= CYC_HALT;
            rd_hist_q <= 1'b1;
            wr_hist_q <= 1'b1;
            wdata_q   <= 8'h00;
        end else begin
            if (ALE) begin
                addr_q <= {a_hi, ad_in};
                iom_q  <= IOMn;
                cyc_q  <= {S1, S0};
            end
            rd_hist_q <= RDn;
            wr_hist_q <= WRn;
            if (!WRn) begin
                wdata_q <= ad_in;
            end
        end
    end

    assign sel_c      = (((addr_q ^ BASE) & HI_MASK) == 16'h0000) && (iom_q == IO_SPACE);
    assign rd_start_c = !RDn && rd_hist_q && WRn;
    assign wr_start_c = !WRn && wr_hist_q && RDn;
    assign both_low_c = !RDn && !WRn;

    // FSM state and registered outputs
    always_ff @(posedge phi1 or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            is_rd_q  <= 1'b0;
            ready_q  <= 1'b1;
            oe_q     <= 1'b0;
            ad_out_q <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_rd_q  <= is_rd_d;
            ready_q  <= ready_d;
            oe_q     <= oe_d;
            ad_out_q <= ad_out_d;
            err_q    <= err_d;
        end
    end

    // Next-state: ALE and simultaneous strobes override everything else
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_rd_d  = is_rd_q;
        ready_d  = ready_q;
        oe_d     = oe_q;
        ad_out_d = ad_out_q;
        err_d    = err_q;
        ram_we_c = 1'b0;

        if (ALE) begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
            oe_d    = 1'b0;
        end else if (both_low_c) begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
            oe_d    = 1'b0;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_c && (cyc_q != CYC_HALT) && (rd_start_c || wr_start_c)) begin
                        is_rd_d = rd_start_c;
                        if ((rd_start_c && (cyc_q == CYC_WRITE)) ||
                            (wr_start_c && (cyc_q != CYC_WRITE))) begin
                            err_d = 1'b1;
                        end
                        if (WAIT_STATES == 0) begin
                            if (rd_start_c) begin
                                state_d  = ST_RD_DRIVE;
                                oe_d     = 1'b1;
                                ad_out_d = rd_data_c;
                            end else begin
                                state_d = ST_WR_HOLD;
                            end
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = WAIT_LOAD;
                            ready_d = 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (is_rd_q ? RDn : WRn) begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                    end else if (cnt_q == '0) begin
                        ready_d = 1'b1;
                        if (is_rd_q) begin
                            state_d  = ST_RD_DRIVE;
                            oe_d     = 1'b1;
                            ad_out_d = rd_data_c;
                        end else begin
                            state_d = ST_WR_HOLD;
                        end
                    end else begin
                        cnt_d = cnt_q - WAIT_CNT_W'(1);
                    end
                end
                ST_RD_DRIVE: begin
                    if (RDn) begin
                        state_d = ST_IDLE;
                        oe_d    = 1'b0;
                    end
                end
                ST_WR_HOLD: begin
                    if (WRn) begin
                        ram_we_c = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    responder_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk     (phi1),
        .we      (ram_we_c),
        .waddr   (addr_q[ADDR_W-1:0]),
        .wdata   (wdata_q),
        .raddr   (addr_q[ADDR_W-1:0]),
        .rdata_c (rd_data_c)
    );

    // Drive enable is gated by live strobes so the bus is released in the cycle RDn rises
    assign ad_oe   = oe_q && !RDn && WRn && !ALE;
    assign ad_out  = ad_out_q;
    assign READY   = ready_q;
    assign bus_err = err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized bench for mem_bus_responder: three wait-state variants share one bus, checked each cycle
// against a transaction-level timeline model plus a few hand-computed literal expectations.
module tb_mem_bus_responder;

    localparam logic [1:0] C_FETCH = 2'b11;
    localparam logic [1:0] C_READ  = 2'b10;
    localparam logic [1:0] C_WRITE = 2'b01;
    localparam logic [1:0] C_HALT  = 2'b00;

    logic       phi1 = 1'b0;
    logic       reset;
    logic       ALE, IOMn, S1, S0, RDn, WRn;
    logic [7:0] a_hi, ad_in;

    logic [7:0] dout_w [3];
    logic [2:0] oe_w, rdy_w, err_w;

    logic [2:0] e_rdy, e_oe, e_dchk;
    logic [7:0] e_dout [3];
    logic       e_err;
    bit         chk_en;
    int         cur_t;

    logic       obs_rdy  [3][16];
    logic       obs_oe   [3][16];
    logic [7:0] obs_dout [3][16];

    logic [7:0] mem_m [256];
    bit         vld   [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 phi1 = ~phi1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_bus_responder #(
            .BASE       (16'h2000),
            .ADDR_W     (8),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3)),
            .IO_SPACE   (1'b0)
        ) u_dut (
            .phi1   (phi1),
            .reset  (reset),
            .ALE    (ALE),
            .IOMn   (IOMn),
            .S1     (S1),
            .S0     (S0),
            .RDn    (RDn),
            .WRn    (WRn),
            .a_hi   (a_hi),
            .ad_in  (ad_in),
            .ad_out (dout_w[g]),
            .ad_oe  (oe_w[g]),
            .READY  (rdy_w[g]),
            .bus_err(err_w[g])
        );
    end

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    // Per-cycle compare against the model expectations
    initial begin
        forever begin
            @(negedge phi1);
            if (chk_en) begin
                for (int i = 0; i < 3; i++) begin
                    n_tests++;
                    if (rdy_w[i] !== e_rdy[i]) begin
                        n_fail++;
                        $display("FAIL ready[ws=%0d] t=%0d @%0t: got %b expected %b", ws_of(i), cur_t, $time, rdy_w[i], e_rdy[i]);
                    end
                    n_tests++;
                    if (oe_w[i] !== e_oe[i]) begin
                        n_fail++;
                        $display("FAIL ad_oe[ws=%0d] t=%0d @%0t: got %b expected %b", ws_of(i), cur_t, $time, oe_w[i], e_oe[i]);
                    end
                    n_tests++;
                    if (err_w[i] !== e_err) begin
                        n_fail++;
                        $display("FAIL bus_err[ws=%0d] t=%0d @%0t: got %b expected %b", ws_of(i), cur_t, $time, err_w[i], e_err);
                    end
                    if (e_dchk[i]) begin
                        n_tests++;
                        if (dout_w[i] !== e_dout[i]) begin
                            n_fail++;
                            $display("FAIL ad_out[ws=%0d] t=%0d @%0t: got %h expected %h", ws_of(i), cur_t, $time, dout_w[i], e_dout[i]);
                        end
                    end
                    if (cur_t >= 0 && cur_t < 16) begin
                        obs_rdy[i][cur_t]  = rdy_w[i];
                        obs_oe[i][cur_t]   = oe_w[i];
                        obs_dout[i][cur_t] = dout_w[i];
                    end
                end
            end
        end
    end

    task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_exp();
        e_rdy  = '1;
        e_oe   = '0;
        e_dchk = '0;
    endtask

    // One bus transaction: ALE, turnaround, strobe low for len cycles, then idle gap.
    // mode 0 = RDn, 1 = WRn, 2 = both strobes; wd < 0 means random write data; rst_at >= 0 pulses reset.
    task automatic access(input logic [15:0] addr, input logic iom, input logic [1:0] cyc,
                          input int mode, input int len, input int wd, input int rst_at);
        bit         sel, start, mism, aborted;
        logic [7:0] off, last;
        sel     = (addr[15:8] == 8'h20) && !iom;
        start   = sel && (cyc != C_HALT) && (mode != 2);
        mism    = start && (((mode == 0) && (cyc == C_WRITE)) || ((mode == 1) && (cyc != C_WRITE)));
        off     = addr[7:0];
        last    = 8'h00;
        aborted = 1'b0;

        @(posedge phi1); #1;
        cur_t = -2; ALE = 1'b1; a_hi = addr[15:8]; ad_in = addr[7:0]; IOMn = iom;
        {S1, S0} = cyc; RDn = 1'b1; WRn = 1'b1;
        idle_exp();
        @(posedge phi1); #1;
        cur_t = -1; ALE = 1'b0; ad_in = 8'($urandom);
        idle_exp();

        for (int t = 0; t < len; t++) begin
            @(posedge phi1); #1;
            cur_t = t;
            if (t == rst_at) begin
                reset   = 1'b0;
                e_err   = 1'b0;
                e_rdy   = '1;
                e_oe    = '0;
                e_dchk  = '1;
                for (int i = 0; i < 3; i++) e_dout[i] = 8'h00;
                aborted = 1'b1;
                break;
            end
            RDn   = !((mode == 0) || (mode == 2));
            WRn   = !((mode == 1) || (mode == 2));
            ad_in = ((mode == 1) && (wd >= 0)) ? 8'(wd) : 8'($urandom);
            if (mode == 1) last = ad_in;
            if ((mism || (mode == 2)) && t >= 1) e_err = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (start) begin
                    e_rdy[i] = !((t >= 1) && (t <= ws_of(i)));
                    e_oe[i]  = (mode == 0) && (t >= ws_of(i) + 1);
                end else begin
                    e_rdy[i] = 1'b1;
                    e_oe[i]  = 1'b0;
                end
                e_dchk[i] = e_oe[i] && vld[off];
                e_dout[i] = mem_m[off];
            end
        end

        for (int g = 0; g < 3; g++) begin
            @(posedge phi1); #1;
            cur_t = len + g;
            reset = 1'b1; RDn = 1'b1; WRn = 1'b1; ALE = 1'b0;
            idle_exp();
        end

        if (!aborted && start && (mode == 1)) begin
            mem_m[off] = last;
            vld[off]   = 1'b1;
        end
    endtask

    initial begin
        logic [15:0] ra;
        logic [1:0]  rc;
        int          rm;

        for (int i = 0; i < 256; i++) begin
            vld[i]   = 1'b0;
            mem_m[i] = 8'h00;
        end
        reset = 1'b0; ALE = 1'b0; IOMn = 1'b0; S1 = 1'b0; S0 = 1'b0;
        RDn = 1'b1; WRn = 1'b1; a_hi = 8'h00; ad_in = 8'h00;
        e_err = 1'b0; cur_t = -3;
        idle_exp();
        e_dchk = '1;
        for (int i = 0; i < 3; i++) e_dout[i] = 8'h00;
        chk_en = 1'b1;

        repeat (3) @(posedge phi1);
        #1;
        reset = 1'b1;
        idle_exp();

        // Write A5 to 2010, read it back, check the WAIT_STATES=1 timeline literally
        access(16'h2010, 1'b0, C_WRITE, 1, 5, 8'hA5, -1);
        access(16'h2010, 1'b0, C_READ, 0, 5, -1, -1);
        lit("ws1_ready_k1", 8'(obs_rdy[1][1]), 8'h00);
        lit("ws1_ready_k2", 8'(obs_rdy[1][2]), 8'h01);
        lit("ws1_oe_k1", 8'(obs_oe[1][1]), 8'h00);
        lit("ws1_oe_k2", 8'(obs_oe[1][2]), 8'h01);
        lit("ws1_data_k2", obs_dout[1][2], 8'hA5);
        lit("ws1_oe_rd_high", 8'(obs_oe[1][5]), 8'h00);

        access(16'h3010, 1'b0, C_READ, 0, 5, -1, -1);
        lit("unsel_addr_oe", 8'(obs_oe[2][4]), 8'h00);
        lit("unsel_addr_ready", 8'(obs_rdy[1][1]), 8'h01);
        access(16'h2010, 1'b1, C_READ, 0, 5, -1, -1);
        lit("io_space_oe", 8'(obs_oe[1][3]), 8'h00);
        lit("io_space_ready", 8'(obs_rdy[1][1]), 8'h01);

        // WAIT_STATES=0 at the top of the window
        access(16'h20FF, 1'b0, C_WRITE, 1, 5, 8'h3C, -1);
        access(16'h20FF, 1'b0, C_READ, 0, 5, -1, -1);
        lit("ws0_oe_k0", 8'(obs_oe[0][0]), 8'h00);
        lit("ws0_oe_k1", 8'(obs_oe[0][1]), 8'h01);
        lit("ws0_data_k1", obs_dout[0][1], 8'h3C);
        lit("ws0_ready_k1", 8'(obs_rdy[0][1]), 8'h01);
        access(16'h2010, 1'b0, C_FETCH, 0, 6, -1, -1);
        lit("fetch_data", obs_dout[2][4], 8'hA5);

        // Random legal traffic
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0:       ra[15:8] = 8'h30;
                1:       ra[15:8] = 8'h21;
                default: ra[15:8] = 8'h20;
            endcase
            case ($urandom_range(0, 5))
                0:       ra[7:0] = 8'hFF;
                1:       ra[7:0] = 8'h00;
                default: ra[7:0] = 8'($urandom_range(0, 15));
            endcase
            rm = int'($urandom_range(0, 1));
            rc = (rm == 1) ? C_WRITE : (($urandom_range(0, 1) == 1) ? C_READ : C_FETCH);
            access(ra, ($urandom_range(0, 9) == 0), rc, rm, int'($urandom_range(5, 7)), -1, -1);
        end

        // Protocol errors and halt
        access(16'h2010, 1'b0, C_HALT, 0, 5, -1, -1);
        lit("halt_no_err", 8'(err_w), 8'h00);
        lit("halt_no_oe", 8'(obs_oe[0][3]), 8'h00);
        access(16'h2005, 1'b0, C_WRITE, 0, 6, -1, -1);
        lit("rd_mismatch_err", 8'(err_w), 8'h07);
        access(16'h2010, 1'b0, C_READ, 2, 3, -1, -1);
        lit("both_low_err", 8'(err_w), 8'h07);
        access(16'h2010, 1'b0, C_READ, 0, 5, -1, -1);
        for (int n = 0; n < 10; n++) begin
            ra = {8'h20, 8'($urandom_range(0, 15))};
            rm = int'($urandom_range(0, 1));
            access(ra, 1'b0, (rm == 1) ? C_WRITE : C_READ, rm, int'($urandom_range(5, 7)), -1, -1);
        end
        lit("err_sticky", 8'(err_w), 8'h07);

        // Reset in the middle of a read and of a write
        access(16'h2010, 1'b0, C_READ, 0, 7, -1, 6);
        lit("rst_rd_oe", 8'(obs_oe[2][6]), 8'h00);
        lit("rst_clears_err", 8'(err_w), 8'h00);
        access(16'h2010, 1'b0, C_WRITE, 1, 6, 8'h5A, 5);
        access(16'h2010, 1'b0, C_READ, 0, 6, -1, -1);

        access(16'h2011, 1'b0, C_READ, 1, 5, 8'h77, -1);
        lit("wr_mismatch_err", 8'(err_w), 8'h07);
        access(16'h2011, 1'b0, C_READ, 0, 6, -1, -1);
        lit("wr_mismatch_data", obs_dout[2][4], 8'h77);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 Parameter BASE, default 16'h0000, base address of the responder window; only bits [15:ADDR_W] are compared.
REQ-002 Parameter ADDR_W, default 8, log2 of window size in bytes (256 bytes).
REQ-003 Parameter WAIT_STATES, default 1, number of cycles READY is held low per access (range 0-7).
REQ-004 Parameter IO_SPACE, default 0, IOMn value this responder answers to (0 = memory, 1 = I/O).
REQ-005 phi1  in  1  sole clock; all state updates on posedge phi1.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 ALE  in  1  address latch enable from the CPU.
REQ-008 IOMn  in  1  I/O (1) / memory (0) select.
REQ-009 S1, S0  in  1 each  bus cycle status: 11 opcode fetch, 10 read, 01 write, 00 halt.
REQ-010 RDn, WRn  in  1 each  active-low read/write strobes.
REQ-011 a_hi  in  8  upper address A15-A8.
REQ-012 ad_in  in  8  multiplexed AD7-AD0 as driven by the CPU.
REQ-013 ad_out  out  8  read data toward AD bus.
REQ-014 ad_oe  out  1  AD bus drive enable.
REQ-015 READY  out  1  wait-state request (0 = insert wait).
REQ-016 bus_err  out  1  sticky protocol-error flag.

Function
REQ-017 Any cycle with ALE=1 SHALL capture {a_hi, ad_in} into the 16-bit address latch, capture IOMn/S1/S0, and force the FSM to IDLE (aborting any access).
REQ-018 sel SHALL be true when latched A[15:ADDR_W]==BASE[15:ADDR_W] and latched IOMn==IO_SPACE.
REQ-019 FSM states: IDLE, WAIT, RD_DRIVE, WR_HOLD.
REQ-020 IDLE->WAIT (or RD_DRIVE/WR_HOLD if WAIT_STATES=0) on the first cycle RDn or WRn is sampled low after being high, with sel true; unselected accesses SHALL be ignored.
REQ-021 WAIT: READY=0 for exactly WAIT_STATES cycles, starting the cycle after the strobe edge; then RD_DRIVE for reads, WR_HOLD for writes.
REQ-022 RD_DRIVE: ad_out=mem[latched A[ADDR_W-1:0]], ad_oe=1, READY=1, held until RDn sampled high; ad_oe SHALL drop in that same cycle, FSM to IDLE.
REQ-023 Read data SHALL be valid with ad_oe in cycle k+WAIT_STATES+1, k = cycle RDn first sampled low.
REQ-024 Opcode fetch (S1S0=11) SHALL be handled identically to read.
REQ-025 WR_HOLD: ad_in SHALL be registered every cycle WRn is low; the last registered byte SHALL be written to memory in the cycle WRn is sampled high; FSM to IDLE.
REQ-026 RDn and WRn sampled low simultaneously SHALL set bus_err, force ad_oe=0, perform no write, and return to IDLE.
REQ-027 Strobe direction mismatching latched S1S0 (RDn with 01, WRn with 10/11) SHALL set bus_err and perform the access per the strobe.
REQ-028 S1S0=00 (halt) SHALL never start an access.
REQ-029 Address offset SHALL be the low ADDR_W bits; no wrap or carry beyond the window.
REQ-030 ad_oe SHALL never be 1 while RDn=1 or ALE=1 in the same cycle.

Reset
REQ-031 While reset=0: ad_oe=0, ad_out=8'h00, READY=1, bus_err=0, FSM=IDLE, address latch=16'h0000, strobe history=high.
REQ-032 Reset asserted mid-access SHALL drop ad_oe asynchronously and cancel any pending write.
REQ-033 Memory contents SHALL NOT be reset.

Structure
REQ-034 Package i8085_bus_pkg SHALL hold the FSM state enum and the S1S0 cycle-type constants (CYC_FETCH, CYC_READ, CYC_WRITE, CYC_HALT).
REQ-035 Storage SHALL be a sub-module responder_ram (2**ADDR_W x 8, one synchronous write port, one read port).

Verification
REQ-036 BASE=16'h2000, WAIT_STATES=1: write 8'hA5 to 16'h2010 (ALE, WRn low 2 cycles, high) -> READY low exactly 1 cycle, mem[16'h10]=8'hA5.
REQ-037 Read 16'h2010 -> READY low 1 cycle, ad_oe=1 with ad_out=8'hA5 at k+2, ad_oe=0 the cycle RDn returns high.
REQ-038 Read 16'h3010 (unselected) and IOMn=1 read of 16'h2010 -> ad_oe stays 0, READY stays 1.
REQ-039 RDn and WRn low together at 16'h2010 -> bus_err=1, no write, ad_oe=0; bus_err holds until reset.
REQ-040 WAIT_STATES=0, read 16'h20FF after write 8'h3C -> ad_out=8'h3C at k+1, READY never low.
REQ-041 reset=0 during RD_DRIVE -> ad_oe=0 immediately; pending write during WR_HOLD not committed; memory retains prior data.
